// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit: multi-cycle multiply sequencer feeding the HI/LO architectural register pair
module mult32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    assign p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
endmodule

module mult32_u (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    assign p = {32'b0, a} * {32'b0, b};
endmodule

module hilo_mult_unit #(
    parameter int LATENCY = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [1:0]  OP,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        BUSY,
    output logic        DONE
);
    typedef enum logic {S_IDLE, S_BUSY} state_t;
    state_t state, state_n;
    logic [3:0] cnt;
    logic [31:0] a_q, b_q;
    logic sgn_q;
    logic [63:0] p_s, p_u, prod;
    logic accept_mul, accept_mt, commit;
    mult32 u_mult (.a(a_q), .b(b_q), .p(p_s));
    mult32_u u_multu (.a(a_q), .b(b_q), .p(p_u));
    // requests are only honoured in IDLE; commit fires when the countdown reaches zero
    always_comb begin
        accept_mul = state == S_IDLE && START && !OP[1];
        accept_mt = state == S_IDLE && START && OP[1];
        commit = state == S_BUSY && cnt == 4'd0;
        state_n = accept_mul ? S_BUSY : commit ? S_IDLE : state;
        prod = sgn_q ? p_s : p_u;
    end
    // state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else state <= state_n;
    end
    // countdown, operand latches, HI/LO writes and the DONE pulse
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= 4'd0;
            a_q <= 32'd0;
            b_q <= 32'd0;
            sgn_q <= 1'b0;
            HI <= 32'd0;
            LO <= 32'd0;
            DONE <= 1'b0;
        end else begin
            DONE <= commit;
            if (accept_mul) begin
                a_q <= A;
                b_q <= B;
                sgn_q <= !OP[0];
                cnt <= 4'(LATENCY - 1);
            end else if (state == S_BUSY && !commit) begin
                cnt <= cnt - 4'd1;
            end
            if (accept_mt && !OP[0]) HI <= A;
            if (accept_mt && OP[0]) LO <= A;
            if (commit) begin
                HI <= prod[63:32];
                LO <= prod[31:0];
            end
        end
    end
    assign BUSY = state == S_BUSY;
endmodule

// File: tb/tb_hilo_mult_unit.sv
// tb_hilo_mult_unit: table-driven and scoreboard checks of the HI/LO multiply unit
module tb_hilo_mult_unit;
    localparam int LAT = 4;
    logic CLK = 1'b0, RST = 1'b1, START = 1'b0;
    logic [1:0] OP = 2'b00;
    logic [31:0] A = 32'd0, B = 32'd0;
    logic [31:0] HI, LO;
    logic BUSY, DONE;
    int checks = 0, errors = 0;
    logic [31:0] mhi = 32'd0, mlo = 32'd0;
    logic [63:0] sb[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;
    vec_t vecs[11];

    hilo_mult_unit #(.LATENCY(LAT)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP), .A(A), .B(B),
        .HI(HI), .LO(LO), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_expect(output logic [63:0] e);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            e = 'x;
        end else e = sb.pop_front();
    endtask

    // called at the first negedge after acceptance has been observed (pre busy cycles already elapsed)
    task automatic finish_mult(input int pre);
        int cyc, busy_n;
        logic [63:0] e;
        cyc = 0;
        busy_n = pre;
        while (!DONE && cyc < 40) begin
            if (BUSY) busy_n++;
            check("hold_hilo", {HI, LO}, {mhi, mlo});
            @(negedge CLK);
            cyc++;
        end
        check("done_seen", DONE, 1);
        check("busy_len", busy_n, LAT);
        pop_expect(e);
        check("product", {HI, LO}, e);
        check("busy_clr", BUSY, 0);
        @(negedge CLK);
        check("done_pulse", DONE, 0);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge CLK);
        START = 1'b1; OP = v.op; A = v.a; B = v.b;
        if (!v.op[1]) sb.push_back({v.hi, v.lo});
        @(negedge CLK);
        START = 1'b0; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
        if (v.op[1]) begin
            check("mt_hilo", {HI, LO}, {v.hi, v.lo});
            check("mt_busy_done", {BUSY, DONE}, 2'b00);
        end else finish_mult(0);
        mhi = v.hi;
        mlo = v.lo;
    endtask

    initial begin
        logic [63:0] e;
        bit saw_done;
        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3]  = '{2'b10, 32'h12345678, 32'h0BADF00D, 32'h12345678, 32'h00000000};
        vecs[4]  = '{2'b11, 32'h9ABCDEF0, 32'h0BADF00D, 32'h12345678, 32'h9ABCDEF0};
        vecs[5]  = '{2'b00, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};
        vecs[6]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[7]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[8]  = '{2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[9]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[10] = '{2'b00, 32'h00000010, 32'h00000010, 32'h00000000, 32'h00000100};

        repeat (2) @(negedge CLK);
        check("reset_state", {HI, LO, BUSY, DONE}, 66'd0);
        RST = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // START while busy is dropped
        @(negedge CLK);
        START = 1'b1; OP = 2'b00; A = 32'd7; B = 32'd6;
        sb.push_back(64'h0000000000000000 | 64'h2A);
        @(negedge CLK);
        OP = 2'b10; A = 32'hDEADBEEF; B = 32'd0;
        @(negedge CLK);
        START = 1'b0;
        finish_mult(1);
        mhi = 32'd0; mlo = 32'h2A;

        // START coincident with the commit edge is ignored, accepted one edge later
        @(negedge CLK);
        START = 1'b1; OP = 2'b00; A = 32'd2; B = 32'd9;
        sb.push_back(64'h12);
        @(negedge CLK);
        START = 1'b0;
        repeat (LAT - 1) @(negedge CLK);
        START = 1'b1; OP = 2'b10; A = 32'hCAFEF00D;
        @(negedge CLK);
        check("commit_edge_done", DONE, 1);
        pop_expect(e);
        check("commit_edge_hilo", {HI, LO}, e);
        @(negedge CLK);
        START = 1'b0;
        check("late_mthi", {HI, LO, BUSY, DONE}, {32'hCAFEF00D, 32'h12, 2'b00});
        mhi = 32'hCAFEF00D; mlo = 32'h12;

        // asynchronous reset mid-multiply discards it
        @(negedge CLK);
        START = 1'b1; OP = 2'b01; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
        @(negedge CLK);
        START = 1'b0;
        check("pre_reset_busy", BUSY, 1);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1 check("async_reset", {HI, LO, BUSY, DONE}, 66'd0);
        @(negedge CLK);
        RST = 1'b0;
        saw_done = 1'b0;
        repeat (LAT + 2) begin
            @(negedge CLK);
            if (DONE || BUSY) saw_done = 1'b1;
        end
        check("no_commit_after_reset", {saw_done, HI, LO}, 65'd0);
        mhi = 32'd0; mlo = 32'd0;
        run_vec('{2'b00, 32'd2, 32'd3, 32'd0, 32'd6});

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hilo_mult_unit.md
Name: hilo_mult_unit

Overview:
Multi-cycle multiply sequencer and HI/LO architectural register pair for the DaVinci datapath, sitting directly downstream of the MULT32 / MULT32_U multipliers. It latches operands on a start request and drives them into internal MULT32 (signed) and MULT32_U (unsigned) instances. After a fixed latency it commits the 64-bit product into the HI/LO registers. It also services MTHI/MTLO writes and presents HI/LO to the MFHI/MFLO read path. BUSY lets the control unit stall dependent instructions.

Parameters:
LATENCY, 4, cycles from accepted START to HI/LO commit for multiply ops; legal range 1..15.

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  asynchronous, active-high reset
START  input  1  request strobe; sampled on rising CLK
OP  input  2  00 = MULT (signed), 01 = MULTU, 10 = MTHI, 11 = MTLO
A  input  32  operand A (rs); also the write data for MTHI/MTLO
B  input  32  operand B (rt); ignored for MTHI/MTLO
HI  output  32  HI register
LO  output  32  LO register
BUSY  output  1  multiply in flight
DONE  output  1  one-cycle pulse after a multiply commit

Behaviour:
- Reset (asynchronous, RST=1):
  - HI=0, LO=0, BUSY=0, DONE=0.
  - State goes to IDLE, counter = 0, operand latches = 0.
  - Takes effect immediately, independent of CLK.
- Reset mid-operation: the in-flight multiply is discarded and never commits. The first START after RST falls is accepted normally.
- State machine has two states: IDLE and BUSY.
- IDLE, START=1, OP=MULT/MULTU at edge t:
  - Latch A, B and the signedness bit.
  - Counter = LATENCY-1.
  - Go to BUSY; BUSY=1 from edge t.
- IDLE, START=1, OP=MTHI/MTLO at edge t:
  - HI (or LO) <= A at edge t; the other register is unchanged.
  - Stays IDLE; BUSY and DONE remain 0.
- BUSY:
  - Counter decrements each edge.
  - On the edge where counter = 0: HI <= product[63:32], LO <= product[31:0], BUSY <= 0, DONE <= 1 for exactly one cycle, state back to IDLE.
  - Commit therefore occurs at edge t+LATENCY.
  - BUSY is high for exactly LATENCY cycles.
- Product source:
  - Signed op uses MULT32 outputs; unsigned op uses MULT32_U outputs.
  - Both are fed only from the latched operands, so A and B may change freely after acceptance.
- START while BUSY (any OP): ignored with no queueing. The counter, latched operands, HI and LO are unaffected. Control must hold the request until BUSY=0.
- START on the same edge as a commit: the controller sees BUSY=1 at that edge, so the request is ignored. It is accepted on the next edge if still asserted.
- HI/LO during BUSY: hold their pre-multiply values. Stalling any read of them is the control unit's job, using BUSY.
- Arithmetic:
  - Full 64-bit product; no truncation and no overflow flag.
  - Signed: two's-complement 32x32 -> 64.
  - Unsigned: 32x32 -> 64.
- DONE is registered, never combinational from START, and is 0 whenever BUSY=1.
- LATENCY=1: BUSY is high for one cycle and DONE pulses the cycle after.

Test Plan:
1. Signed multiply, LATENCY=4: START, OP=00, A=FFFFFFFF, B=00000002 -> BUSY high for 4 cycles, then HI=FFFFFFFF, LO=FFFFFFFE, DONE pulses once.
2. Unsigned multiply and signed corner: OP=01, A=FFFFFFFF, B=00000002 -> HI=00000001, LO=FFFFFFFE. Then OP=00, A=B=80000000 -> HI=40000000, LO=00000000.
3. Move-to and hold: OP=10, A=12345678 -> HI=12345678 next edge with BUSY=0 and LO unchanged. Then OP=11, A=9ABCDEF0 -> LO=9ABCDEF0. Then MULT 3*5 -> during BUSY, HI/LO still 12345678/9ABCDEF0; after commit HI=0, LO=0000000F.
4. START during BUSY: begin MULT 7*6, then assert START with OP=10, A=DEADBEEF at busy cycle 2 -> ignored; final HI=0, LO=0000002A; BUSY duration unchanged.
5. Reset mid-operation: MULT FFFFFFFF*FFFFFFFF (unsigned), assert RST asynchronously at busy cycle 2 -> HI=LO=0 and BUSY=0 immediately; no DONE pulse. A new MULT 2*3 then completes with LO=00000006.
6. Operand change after accept: START with A=00000010, B=00000010, then change A=B=FFFFFFFF on the next cycle -> result is LO=00000100, HI=0.
